// File: rtl/sort_tb_pkg.sv
// Shared definitions for the sort-array test-harness loader: state encoding,
// data width and default load geometry.
package sort_tb_pkg;

    localparam int DATA_W = 64;

    localparam int          DEF_NUM_ELEMS = 8;
    localparam int          DEF_STRIDE    = 8;
    localparam logic [63:0] DEF_BASE_ADDR = 64'd0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage : sort_tb_pkg

// File: rtl/pc_stall_detector.sv
// Flags a finished program: the PC has repeated for STALL_CYCLES consecutive
// compared samples while enabled. The first enabled cycle only captures the PC.
module pc_stall_detector
    import sort_tb_pkg::*;
#(
    parameter int STALL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] pc,
    output logic              stalled
);

    localparam int CW = $clog2(STALL_CYCLES + 1);

    logic [DATA_W-1:0] prev_pc;
    logic              first;
    logic [CW-1:0]     stall_cnt;
    logic              pc_match;

    assign pc_match = (pc == prev_pc);
    assign stalled  = enable && !first && pc_match && (stall_cnt == CW'(STALL_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc   <= '0;
            first     <= 1'b1;
            stall_cnt <= '0;
        end else if (enable) begin
            prev_pc <= pc;
            first   <= 1'b0;
            if (!first) begin
                stall_cnt <= pc_match ? stall_cnt + CW'(1) : '0;
            end
        end else begin
            // Re-arm so the next run starts with a capture-only cycle.
            first     <= 1'b1;
            stall_cnt <= '0;
        end
    end

endmodule : pc_stall_detector

// File: rtl/sort_array_loader.sv
// Harness controller: holds the core in reset while streaming elements into
// data memory, then releases it and waits for a PC self-loop or the watchdog.
module sort_array_loader
    import sort_tb_pkg::*;
#(
    parameter int          NUM_ELEMS      = DEF_NUM_ELEMS,
    parameter logic [63:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int          STRIDE         = DEF_STRIDE,
    parameter int          STALL_CYCLES   = 4,
    parameter int          MAX_RUN_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             mem_we,
    output logic [63:0]                      mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    output logic                             core_reset,
    input  logic [63:0]                      pc_out,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [$clog2(NUM_ELEMS+1)-1:0]   load_count,
    output logic [31:0]                      run_cycles
);

    localparam int LCW = $clog2(NUM_ELEMS + 1);

    state_t state;
    logic   accept;
    logic   restart;
    logic   stalled;
    logic   watchdog;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign restart  = start && ((state == IDLE) || (state == DONE));
    assign watchdog = (run_cycles == 32'(MAX_RUN_CYCLES - 1));

    pc_stall_detector #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_stall (
        .clk    (clk),
        .reset  (reset),
        .enable (state == RUN),
        .pc     (pc_out),
        .stalled(stalled)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            load_count <= '0;
            run_cycles <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                state      <= LOAD;
                core_reset <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
                timeout    <= 1'b0;
                load_count <= '0;
                run_cycles <= '0;
                mem_addr   <= BASE_ADDR;
            end else begin
                case (state)
                    LOAD: begin
                        if (accept) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= BASE_ADDR + 64'(load_count) * 64'(STRIDE);
                            mem_wdata  <= in_data;
                            load_count <= load_count + LCW'(1);
                            if (load_count == LCW'(NUM_ELEMS - 1)) begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end
                    RUN: begin
                        if (run_cycles != 32'hFFFF_FFFF) begin
                            run_cycles <= run_cycles + 32'd1;
                        end
                        // A genuine finish takes precedence over a coincident watchdog expiry.
                        if (stalled) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b0;
                        end else if (watchdog) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : sort_array_loader

// File: tb/tb_sort_array_loader.sv
// Directed bench for sort_array_loader: load, stall completion, watchdog,
// restart and mid-load reset.
module tb_sort_array_loader;
    import sort_tb_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        core_reset;
    logic [63:0] pc_out;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [3:0]  load_count;
    logic [31:0] run_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] vals [8] = '{64'd5, 64'd3, 64'd8, 64'd1, 64'd7, 64'd2, 64'd6, 64'd4};

    sort_array_loader #(
        .NUM_ELEMS     (8),
        .BASE_ADDR     (64'd0),
        .STRIDE        (8),
        .STALL_CYCLES  (4),
        .MAX_RUN_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_reset(core_reset),
        .pc_out    (pc_out),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .load_count(load_count),
        .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start from IDLE/DONE and confirm the cleared LOAD entry state.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_core_reset", core_reset, 1);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_timeout", timeout, 0);
        check("start_load_count", load_count, 0);
        check("start_run_cycles", run_cycles, 0);
        check("start_in_ready", in_ready, 1);
    endtask

    // Stream the eight values, optionally idling in_valid between them.
    task automatic load_all(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            check("load_in_ready", in_ready, 1);
            check("load_core_reset", core_reset, 1);
            tick();
            check("load_we", mem_we, 1);
            check("load_addr", mem_addr, 64'(i * 8));
            check("load_wdata", mem_wdata, vals[i]);
            check("load_count", load_count, 64'(i + 1));
            if (gaps && i < 7) begin
                in_valid = 1'b0;
                in_data  = 64'hDEAD;
                tick();
                check("gap_we", mem_we, 0);
                check("gap_addr_hold", mem_addr, 64'(i * 8));
                check("gap_wdata_hold", mem_wdata, vals[i]);
            end
        end
        in_valid = 1'b0;
        check("release_core_reset", core_reset, 1);
        check("release_busy", busy, 1);
        check("release_in_ready", in_ready, 0);
        tick();
        check("run_core_reset", core_reset, 0);
        check("run_we", mem_we, 0);
        check("run_busy", busy, 1);
    endtask

    // Drive one PC per RUN cycle; completion expected on the n-th edge.
    task automatic run_pcs(input int mode, input int n, input bit exp_to, input int start_at);
        for (int k = 1; k <= n; k++) begin
            case (mode)
                0:       pc_out = (k <= 4)  ? 64'(4 * (k - 1)) : 64'd12;
                1:       pc_out = 64'(4 * (k - 1));
                default: pc_out = (k <= 12) ? 64'(4 * (k - 1)) : 64'd44;
            endcase
            start = (k == start_at);
            tick();
            start = 1'b0;
            if (k < n) begin
                check("run_not_done", done, 0);
                check("run_core_reset_low", core_reset, 0);
            end
        end
        check("done", done, 1);
        check("timeout", timeout, exp_to);
        check("run_cycles", run_cycles, 64'(n));
        check("done_core_reset", core_reset, 0);
        check("done_busy", busy, 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        pc_out   = '0;
        tick();
        tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_load_count", load_count, 0);
        reset = 1'b1;
        tick();
        check("idle_core_reset", core_reset, 1);
        check("idle_in_ready", in_ready, 0);

        // Back-to-back load, then stall completion after four repeated PCs.
        do_start();
        load_all(1'b0);
        run_pcs(0, 8, 1'b0, 0);

        // Gapped load, watchdog expiry; start during RUN must be ignored.
        do_start();
        load_all(1'b1);
        run_pcs(1, 16, 1'b1, 3);

        // in_valid while DONE must not write.
        in_valid = 1'b1;
        in_data  = 64'h55;
        tick();
        check("done_ignore_valid_we", mem_we, 0);
        check("done_still_done", done, 1);
        in_valid = 1'b0;

        // Restart from DONE; stall and watchdog coincide, stall wins.
        do_start();
        check("restart_addr", mem_addr, 0);
        load_all(1'b0);
        run_pcs(2, 16, 1'b0, 0);

        // Asynchronous reset in the middle of a load.
        do_start();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vals[i];
            tick();
        end
        check("pre_rst_we", mem_we, 1);
        check("pre_rst_count", load_count, 3);
        #2;
        reset = 1'b0;
        #1;
        check("async_core_reset", core_reset, 1);
        check("async_we", mem_we, 0);
        check("async_count", load_count, 0);
        check("async_in_ready", in_ready, 0);
        check("async_busy", busy, 0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 0);
        check("post_rst_we", mem_we, 0);
        check("post_rst_core_reset", core_reset, 1);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sort_array_loader

// File: doc/sort_array_loader.md
Name: sort_array_loader

Overview:
- Test-harness controller that owns the processor's start-up and completion.
- Holds the RISC-V core in reset while it streams NUM_ELEMS 64-bit unsorted elements into data memory over a write port.
- Then releases the core and watches its PC for the terminal self-loop, or for a watchdog timeout, and flags completion.
- Sits between the stimulus source and the RISC_V_processor's reset input and data-memory write port.

Parameters:
NUM_ELEMS, 8, elements loaded per run
BASE_ADDR, 0, byte address of element 0
STRIDE, 8, byte distance between elements
STALL_CYCLES, 4, consecutive repeated-PC samples that mean "program finished"
MAX_RUN_CYCLES, 4096, watchdog limit on RUN cycles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin load
in_valid  in  1  element available
in_data  in  64  element value
in_ready  out  1  loader accepts element this cycle
mem_we  out  1  data-memory write strobe
mem_addr  out  64  data-memory byte address
mem_wdata  out  64  data-memory write data
core_reset  out  1  active-high reset to the processor
pc_out  in  64  processor PC
busy  out  1  LOAD, RELEASE or RUN in progress
done  out  1  run complete
timeout  out  1  completion was caused by the watchdog
load_count  out  $clog2(NUM_ELEMS+1)  elements accepted
run_cycles  out  32  cycles spent in RUN

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- While reset=0, asynchronously force:
  - state=IDLE, core_reset=1;
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0;
  - busy=0, done=0, timeout=0, load_count=0, run_cycles=0, stall counter=0.
  - This applies mid-operation too: core_reset rises immediately and any in-flight write is dropped.
- IDLE:
  - core_reset=1, in_ready=0.
  - start=1 -> LOAD.
- LOAD:
  - core_reset=1; in_ready=1 combinationally while state==LOAD.
  - An element is accepted on an edge with in_valid&&in_ready.
  - Next cycle: mem_we=1, mem_addr=BASE_ADDR+idx*STRIDE, mem_wdata=accepted data. Write latency is exactly 1 cycle.
  - mem_we=0 on cycles with no acceptance the previous cycle; mem_addr and mem_wdata hold their last value.
  - load_count increments per accept.
  - Acceptance of element NUM_ELEMS-1 -> RELEASE.
- RELEASE (1 cycle):
  - Final mem_we pulse occurs here; core_reset still 1.
  - -> RUN.
- RUN:
  - core_reset=0. run_cycles increments each cycle, saturating at 2^32-1.
  - prev_pc is registered each cycle. The first RUN cycle performs no comparison.
  - Stall counter rule:
    - On each later cycle, pc_out==prev_pc increments the stall counter; otherwise it clears to 0.
    - A match while the counter equals STALL_CYCLES-1 -> DONE with timeout=0.
  - Watchdog: an edge with run_cycles==MAX_RUN_CYCLES-1 -> DONE with timeout=1.
  - If stall completion and watchdog fire on the same edge, stall wins (timeout=0).
- DONE:
  - done=1, busy=0, core_reset stays 0 so the core keeps spinning and memory is readable.
  - start=1 -> LOAD, with core_reset=1, load_count=0, run_cycles=0, done=0, timeout=0 and mem_addr reset to BASE_ADDR.
- Ignored inputs:
  - start is ignored in LOAD, RELEASE and RUN.
  - in_valid is ignored outside LOAD; no write is generated.
- busy=1 exactly in LOAD, RELEASE and RUN.
- Address width: idx*STRIDE is computed in 64 bits with no wrap check; the parameter choice guarantees range.

Decomposition:
- Shared package sort_tb_pkg:
  - state encoding localparams (IDLE=0 … DONE=4);
  - default NUM_ELEMS, STRIDE and BASE_ADDR;
  - data width of 64.
- One sub-module, pc_stall_detector:
  - inputs: clk, reset, enable, pc;
  - output: stalled pulse;
  - owns prev_pc, the first-cycle suppression and the stall counter;
  - parameter STALL_CYCLES.

Test Plan:
1. Stream 5,3,8,1,7,2,6,4 with in_valid held high after start -> in_ready high 8 cycles; mem_we pulses at addresses 0,8,…,56 with those data, each 1 cycle after its accept; core_reset falls 2 cycles after the last accept; load_count=8.
2. Same data with in_valid low on alternate cycles -> exactly 8 write pulses, contiguous addresses, no write on idle cycles; RELEASE still lasts 1 cycle.
3. In RUN, drive pc_out 0,4,8,12,12,12,12,12 with STALL_CYCLES=4 -> done=1, timeout=0 on the cycle after the 4th repeated 12; run_cycles=8; core_reset stays 0.
4. MAX_RUN_CYCLES=16 with pc_out incrementing every cycle -> done=1, timeout=1 after exactly 16 RUN cycles; run_cycles=16.
5. Pulse start during RUN -> no effect. Pulse start in DONE -> core_reset=1 the next cycle, counters cleared, a new 8-element load writes from address 0 again.
6. Drive reset=0 during LOAD after 3 accepts -> core_reset=1 and mem_we=0 asynchronously; IDLE, load_count=0; in_ready=0 until the next start.
